// File: rtl/serial_port_pkg.sv
// serial_port_pkg: types and constants shared by the serial_port UART PHY.
//   - tx_state_e / rx_state_e : state encodings of the TX and RX framers
//   - FRAME_BITS              : bits per 8N1 frame (start + 8 data + stop)
//   - DATA_BITS               : payload bits per frame
//   - make_frame()            : builds the LSB-first shift image of one frame
package serial_port_pkg;

  localparam int FRAME_BITS = 10;
  localparam int DATA_BITS  = 8;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_WAIT_HIGH,
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  // Bit 0 goes out first: start bit (0), data LSB first, stop bit (1).
  function automatic logic [FRAME_BITS-1:0] make_frame(input logic [DATA_BITS-1:0] b);
    return {1'b1, b, 1'b0};
  endfunction

endpackage

// File: rtl/serial_port_sync_fifo.sv
// sync_fifo: single-clock FIFO with a combinational (fall-through) head.
// Ports:
//   clk, rst        clock, synchronous active-high reset (empties the FIFO)
//   wr_en, wr_data  push request and data
//   rd_en           pop request (ignored while empty)
//   rd_data         current head entry (valid only while !empty)
//   empty, full     status flags
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// A push while full is still accepted when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_rd;
  logic             do_wr;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is not reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/serial_port.sv
// serial_port: byte-serial 8N1 UART PHY for the SoC console.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   tx_data, tx_strobe     byte to send, one-cycle push into the TX FIFO
//   tx_full                TX FIFO full (a strobe now is dropped)
//   rx_data, rx_valid      head of the RX FIFO, RX FIFO non-empty
//   rx_ack                 one-cycle pop of the RX head
//   rx_overrun             sticky: a good frame was dropped, RX FIFO full
//   frame_err              one-cycle pulse: stop bit sampled low
//   uart_txd               serial output, idle high, registered
//   uart_rxd               asynchronous serial input
// CLKS_PER_BIT must be at least 4; FIFO_DEPTH a power of two, at least 2.
module serial_port
  import serial_port_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_strobe,
  output logic       tx_full,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       rx_overrun,
  output logic       frame_err,
  output logic       uart_txd,
  input  logic       uart_rxd
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]    DATA_LAST = 3'(DATA_BITS - 1);

  // ---------------------------------------------------------------- TX path
  tx_state_e             tx_state_q, tx_state_d;
  logic [CW-1:0]         tx_cnt_q, tx_cnt_d;
  logic [2:0]            tx_bit_q, tx_bit_d;
  logic [FRAME_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                  txd_q, txd_d;
  logic                  tx_pop;
  logic                  tx_empty;
  logic [7:0]            tx_head;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (tx_strobe),
    .wr_data (tx_data),
    .rd_en   (tx_pop),
    .rd_data (tx_head),
    .empty   (tx_empty),
    .full    (tx_full)
  );

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_shift_d = make_frame(tx_head);
          tx_cnt_d   = '0;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_shift_d = {1'b1, tx_shift_q[FRAME_BITS-1:1]};
          tx_state_d = TX_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_shift_d = {1'b1, tx_shift_q[FRAME_BITS-1:1]};
          if (tx_bit_q == DATA_LAST) tx_state_d = TX_STOP;
          else                       tx_bit_d   = tx_bit_q + 1'b1;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          // Chain straight into the next frame so queued bytes leave gap-free.
          if (!tx_empty) begin
            tx_pop     = 1'b1;
            tx_shift_d = make_frame(tx_head);
            tx_state_d = TX_START;
          end else begin
            tx_state_d = TX_IDLE;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
    // The pin register trails the shifter by one cycle, so every bit still
    // lasts CLKS_PER_BIT cycles and the pin never sees a combinational glitch.
    txd_d = (tx_state_q == TX_IDLE) ? 1'b1 : tx_shift_q[0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '1;
      txd_q      <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      txd_q      <= txd_d;
    end
  end

  assign uart_txd = txd_q;

  // ---------------------------------------------------------------- RX path
  rx_state_e     rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic          rxd_meta_q, rxd_sync_q;
  logic          overrun_q, overrun_d;
  logic          frame_err_q, frame_err_d;
  logic          rx_push;
  logic          rx_can_push;
  logic          rx_empty;
  logic          rx_fifo_full;
  logic [7:0]    rx_head;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (rx_push),
    .wr_data (rx_shift_q),
    .rd_en   (rx_ack),
    .rd_data (rx_head),
    .empty   (rx_empty),
    .full    (rx_fifo_full)
  );

  // Mirrors the FIFO's own accept rule: a full FIFO still takes the byte
  // when the SoC pops in the same cycle.
  assign rx_can_push = !rx_fifo_full || (rx_ack && !rx_empty);

  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    overrun_d   = overrun_q;
    frame_err_d = 1'b0;
    rx_push     = 1'b0;
    case (rx_state_q)
      RX_WAIT_HIGH: begin
        if (rxd_sync_q) rx_state_d = RX_IDLE;
      end
      RX_IDLE: begin
        if (!rxd_sync_q) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        // Half a bit in: still low means a real start bit, and every later
        // sample lands near the middle of its bit.
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d = '0;
          rx_bit_d = '0;
          if (rxd_sync_q) rx_state_d = RX_IDLE;
          else            rx_state_d = RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rxd_sync_q, rx_shift_q[7:1]};
          if (rx_bit_q == DATA_LAST) rx_state_d = RX_STOP;
          else                       rx_bit_d   = rx_bit_q + 1'b1;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d = '0;
          if (rxd_sync_q) begin
            if (rx_can_push) rx_push   = 1'b1;
            else             overrun_d = 1'b1;
            rx_state_d = RX_IDLE;
          end else begin
            // Line may be in a break; wait for it to return high before
            // hunting for the next start bit.
            frame_err_d = 1'b1;
            rx_state_d  = RX_WAIT_HIGH;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      default: rx_state_d = RX_WAIT_HIGH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_meta_q  <= 1'b1;
      rxd_sync_q  <= 1'b1;
      rx_state_q  <= RX_WAIT_HIGH;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_shift_q  <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rxd_meta_q  <= uart_rxd;
      rxd_sync_q  <= rxd_meta_q;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign rx_valid   = !rx_empty;
  assign rx_data    = rx_empty ? 8'h00 : rx_head;
  assign rx_overrun = overrun_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_serial_port.sv
// tb_serial_port: directed self-checking bench for serial_port
// (CLKS_PER_BIT=4, FIFO_DEPTH=16). All activity happens on the falling edge.
module tb_serial_port;

  localparam int CPB = 4;
  localparam int FW  = 10 * CPB;

  logic       clk;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_strobe;
  logic       tx_full;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack;
  logic       rx_overrun;
  logic       frame_err;
  logic       uart_txd;
  logic       uart_rxd;

  int n_checks = 0;
  int n_fails  = 0;
  int fe_count = 0;

  serial_port #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_data    (tx_data),
    .tx_strobe  (tx_strobe),
    .tx_full    (tx_full),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ack     (rx_ack),
    .rx_overrun (rx_overrun),
    .frame_err  (frame_err),
    .uart_txd   (uart_txd),
    .uart_rxd   (uart_rxd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts cycles with frame_err high, so a stuck pulse shows up as >1.
  always @(negedge clk) begin
    if (!rst && frame_err) fe_count = fe_count + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected uart_txd waveform of one frame, one entry per clock, bit 0 first.
  function automatic logic [FW-1:0] tx_wave(input logic [7:0] b);
    logic [9:0]    f;
    logic [FW-1:0] w;
    f = {1'b1, b, 1'b0};
    for (int k = 0; k < FW; k++) w[k] = f[k / CPB];
    return w;
  endfunction

  task automatic capture(input int n, output logic [63:0] bits);
    bits = '0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      bits[k] = uart_txd;
    end
  endtask

  // Drive one frame on uart_rxd; the stop level is held tail extra cycles,
  // then the line idles high for 4 cycles.
  task automatic rx_send(input logic [7:0] b, input logic stop_bit, input int tail);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      uart_rxd = f[k];
      repeat (CPB - 1) @(negedge clk);
    end
    repeat (tail) @(negedge clk);
    @(negedge clk);
    uart_rxd = 1'b1;
    repeat (4) @(negedge clk);
    $display("rx frame 0x%02h stop=%0b sent", b, stop_bit);
  endtask

  task automatic rx_pop(input logic [7:0] exp, input string tag);
    check($sformatf("%s_valid", tag), rx_valid, 1);
    check($sformatf("%s_data", tag), rx_data, exp);
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
    $display("rx byte popped, expected 0x%02h", exp);
  endtask

  logic [63:0] got;

  initial begin
    rst       = 1'b1;
    uart_rxd  = 1'b1;
    tx_data   = 8'h00;
    tx_strobe = 1'b0;
    rx_ack    = 1'b0;

    // 1. reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_txd", uart_txd, 1);
    check("rst_tx_full", tx_full, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_overrun", rx_overrun, 0);
    check("rst_frame_err", frame_err, 0);
    repeat (3) @(negedge clk);

    // 2. single TX byte 0x42, start bit at N+2
    tx_data   = 8'h42;
    tx_strobe = 1'b1;
    @(negedge clk);               // cycle N
    tx_strobe = 1'b0;
    check("tx42_cycle_n", uart_txd, 1);
    capture(1, got);              // cycle N+1
    check("tx42_cycle_n1", got, 64'h1);
    capture(FW, got);
    check("tx42_frame", got, tx_wave(8'h42));
    capture(20, got);
    check("tx42_idle_after", got, 64'hF_FFFF);
    $display("tx frame 0x42 checked");

    // 3. RX 0xA5, then pop
    rx_send(8'hA5, 1'b1, 0);
    rx_pop(8'hA5, "rxA5");
    check("rxA5_valid_after_ack", rx_valid, 0);

    // 4. 18 strobes 0x00..0x11, FIFO fills after the 17th
    tx_data   = 8'h00;
    tx_strobe = 1'b1;
    fork
      begin
        for (int i = 1; i < 18; i++) begin
          @(negedge clk);
          if (i == 16) check("burst_tx_full_16", tx_full, 0);
          if (i == 17) check("burst_tx_full_17", tx_full, 1);
          tx_data = 8'(i);
        end
        @(negedge clk);
        tx_strobe = 1'b0;
      end
      begin
        capture(2, got);          // cycles N, N+1
        check("burst_pre", got, 64'h3);
        for (int f = 0; f < 17; f++) begin
          capture(FW, got);
          check($sformatf("burst_frame_%0d", f), got, tx_wave(8'(f)));
          $display("tx burst frame 0x%02h checked", f);
        end
        capture(60, got);
        check("burst_no_0x11", got, 64'h0FFF_FFFF_FFFF_FFFF);
      end
    join
    check("burst_tx_full_drained", tx_full, 0);

    // 5. framing error, then a good frame
    rx_send(8'h3C, 1'b0, 20);
    check("fe_pulse_count", fe_count, 1);
    check("fe_rx_valid", rx_valid, 0);
    rx_send(8'h3C, 1'b1, 0);
    check("fe_no_extra_pulse", fe_count, 1);
    rx_pop(8'h3C, "rx3C");

    // 6. overrun, drain, glitch
    for (int i = 1; i <= 17; i++) begin
      rx_send(8'(i), 1'b1, 0);
      if (i == 16) check("ovr_before", rx_overrun, 0);
    end
    check("ovr_set", rx_overrun, 1);
    for (int i = 1; i <= 16; i++) rx_pop(8'(i), $sformatf("drain_%0d", i));
    check("drain_empty", rx_valid, 0);
    check("ovr_sticky", rx_overrun, 1);
    @(negedge clk);
    uart_rxd = 1'b0;
    @(negedge clk);
    uart_rxd = 1'b1;
    repeat (20) @(negedge clk);
    check("glitch_no_byte", rx_valid, 0);
    check("glitch_no_fe", fe_count, 1);

    // 7. reset in the middle of a TX frame
    tx_data   = 8'h00;
    tx_strobe = 1'b1;
    @(negedge clk);               // cycle N
    tx_strobe = 1'b0;
    repeat (12) @(negedge clk);   // cycle N+12, data bit of 0x00
    check("midrst_txd_low", uart_txd, 0);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_txd_high", uart_txd, 1);
    check("midrst_ovr_clr", rx_overrun, 0);
    rst = 1'b0;
    capture(60, got);
    check("midrst_idle", got, 64'h0FFF_FFFF_FFFF_FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
